// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet framer.
package ps2_pkg;

  typedef enum logic [1:0] {
    BYTE1 = 2'd0,
    BYTE2 = 2'd1,
    BYTE3 = 2'd2,
    DONE  = 2'd3
  } ps2_frame_state_t;

  localparam int SYNC_BIT = 3;

endpackage

// File: rtl/ps2_byte_framer_if.sv
// Byte stream in from the PS/2 receiver, packet-done pulse out to the decoder.
interface ps2_byte_framer_if;

  logic [7:0] in;
  logic       done;

  modport master (output in, input done);
  modport slave  (input in, output done);

endinterface

// File: rtl/ps2_byte_framer.sv
// Hunts for the byte with the sync bit set, counts two more bytes, then flags done.
module ps2_byte_framer
  import ps2_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ps2_byte_framer_if.slave   bus
);

  ps2_frame_state_t state_reg;
  ps2_frame_state_t state_next;
  logic             sync;

  // Only the sync bit is read, so unknowns on the other bits cannot reach done.
  assign sync = bus.in[SYNC_BIT];

  always_comb begin
    state_next = BYTE1;
    case (state_reg)
      BYTE1:   state_next = sync ? BYTE2 : BYTE1;
      BYTE2:   state_next = BYTE3;
      BYTE3:   state_next = DONE;
      DONE:    state_next = sync ? BYTE2 : BYTE1;
      default: state_next = BYTE1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BYTE1;
    end else begin
      state_reg <= state_next;
    end
  end

  assign bus.done = (state_reg == DONE);

endmodule

// File: tb/tb_ps2_byte_framer.sv
// Scoreboard bench: a reference FSM queues expected done per byte, compared after each edge.
module tb_ps2_byte_framer;

  logic clk;
  logic reset;

  ps2_byte_framer_if bus ();

  ps2_byte_framer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  int   model_state;
  logic exp_q[$];
  logic exp_last;
  bit   have_exp;

  task automatic check_eq(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b want %0b at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: 0 hunting, 1 second byte, 2 third byte, 3 packet complete.
  task automatic model_step(input logic r, input logic [7:0] b);
    if (r) model_state = 0;
    else if (model_state == 1) model_state = 2;
    else if (model_state == 2) model_state = 3;
    else if (b[3]) model_state = 1;
    else model_state = 0;
  endtask

  task automatic step(input string tag, input logic r, input logic [7:0] b);
    logic exp;
    @(negedge clk);
    if (have_exp) check_eq({tag, "_neg"}, bus.done, exp_last);
    reset  = r;
    bus.in = b;
    model_step(r, b);
    exp_q.push_back(model_state == 3);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, bus.done, exp);
      exp_last = exp;
      have_exp = 1'b1;
    end
    $display("%s reset=%0b in=%02h done=%0b", tag, r, b, bus.done);
  endtask

  int pulses;

  initial begin
    checks      = 0;
    errors      = 0;
    model_state = 0;
    have_exp    = 1'b0;
    exp_last    = 1'b0;
    reset       = 1'b1;
    bus.in      = 8'h00;

    step("rst", 1'b1, 8'h08);
    step("rst", 1'b1, 8'h00);
    check_eq("rst_done", bus.done, 1'b0);

    // Single packet: done only after the third byte.
    step("t1", 1'b0, 8'h08);
    check_eq("t1_b1", bus.done, 1'b0);
    step("t1", 1'b0, 8'h00);
    check_eq("t1_b2", bus.done, 1'b0);
    step("t1", 1'b0, 8'h00);
    check_eq("t1_b3", bus.done, 1'b1);
    step("t1", 1'b0, 8'h00);
    check_eq("t1_after", bus.done, 1'b0);

    // No sync bit: stays hunting.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step("t2", 1'b0, (i % 2 == 0) ? 8'h00 : 8'hF7);
      if (bus.done) pulses++;
    end
    check_eq("t2_no_pulse", pulses == 0, 1'b1);

    // Back-to-back packets.
    begin
      logic [7:0] t3[7];
      t3 = '{8'h08, 8'h01, 8'h02, 8'h0C, 8'h03, 8'h04, 8'h00};
      pulses = 0;
      for (int i = 0; i < 7; i++) begin
        step("t3", 1'b0, t3[i]);
        if (bus.done) pulses++;
        if (i == 2 || i == 5) check_eq("t3_pulse", bus.done, 1'b1);
      end
      check_eq("t3_count", pulses == 2, 1'b1);
    end

    // Data bytes with bit 3 set are not re-sync points.
    step("t4", 1'b0, 8'h08);
    step("t4", 1'b0, 8'h08);
    step("t4", 1'b0, 8'h08);
    check_eq("t4_pulse", bus.done, 1'b1);
    step("t4", 1'b0, 8'h00);
    check_eq("t4_hunt", bus.done, 1'b0);
    step("t4", 1'b0, 8'h00);
    step("t4", 1'b0, 8'h00);
    check_eq("t4_still_hunt", bus.done, 1'b0);

    // Reset mid-packet abandons it.
    pulses = 0;
    step("t5", 1'b0, 8'h08);
    step("t5", 1'b1, 8'h08);
    for (int i = 0; i < 3; i++) begin
      step("t5", 1'b0, 8'h00);
      if (bus.done) pulses++;
    end
    check_eq("t5_no_pulse", pulses == 0, 1'b1);

    // Random stream with occasional reset.
    for (int i = 0; i < 200; i++) begin
      step("t6", ($urandom_range(31) == 0), 8'($urandom_range(255)));
    end

    @(negedge clk);
    check_eq("final_neg", bus.done, exp_last);
    check_eq("queue_drained", exp_q.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
